kbd_text_writer: RTL and testbench
==================================

// Module: kbd_text_writer
// PURPOSE
//  Converts PS/2 set-2 scan-code bytes into character writes for the 16-cell
//  VGA text buffer. Tracks a cursor, drops key-release and extended sequences,
//  handles backspace/enter/escape-clear, and drives the buffer write port.
//  Sits between the PS/2 byte receiver (upstream) and the text buffer (downstream).
// PARAMETERS
//  NUM_REGS  16        number of text cells; cursor range 0..NUM_REGS-1
//  ADDR_W    4         width of wr_addr/cursor, = clog2(NUM_REGS)
//  SIZE      32        width of wr_data
//  BLANK     32'h120   cell value for an empty cell (attribute bit8=1, ASCII space)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       asynchronous reset, active-low
//  scan_valid  in   1       1-cycle strobe: scan_code holds a new byte
//  scan_code   in   8       PS/2 set-2 byte
//  wr_en       out  1       1-cycle write pulse to text buffer
//  wr_addr     out  ADDR_W  cell being written
//  wr_data     out  SIZE    {23'b0, 1'b1, ascii[7:0]} or BLANK
//  cursor      out  ADDR_W  next cell to be written
//  busy        out  1       high during clear sweep; bytes arriving then are dropped
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, wr_en=0, wr_addr=0, wr_data=BLANK,
//    cursor=0, busy=0. Reset during a clear sweep aborts it; no further writes.
//  - All outputs registered. Byte accepted when scan_valid=1 and busy=0.
//    Write caused by an accepted byte: wr_en=1 in cycle N+1 (N = accept cycle).
//  - wr_en high exactly one cycle per write, except CLR (one write per cycle).
//  - Map: letters A-Z -> uppercase ASCII 0x41-0x5A (e.g. 1C->'A', 32->'B',
//    21->'C', 23->'D', 24->'E'); digits 45->'0', 16->'1' ... 46->'9';
//    29->space 0x20. Special: 66=backspace, 5A=enter, 76=escape. Every other
//    byte, incl. shift 12/59, is unmapped and ignored (no write, no move).
//  - FSM states: IDLE, BRK, EXT, EXT_BRK, CLR.
//    IDLE: F0->BRK; E0->EXT; printable -> write ascii at cursor,
//      cursor <= (cursor+1) mod NUM_REGS (15 wraps to 0);
//      backspace: cursor>0 -> cursor-1 and write BLANK at cursor-1;
//      cursor=0 -> no write, no move;
//      enter -> cursor <= 0, no write; escape -> CLR, busy=1 next cycle.
//    BRK: next accepted byte (any value, incl. F0/E0) discarded -> IDLE.
//    EXT: F0 -> EXT_BRK; any other byte discarded -> IDLE (no E0 keys mapped).
//    EXT_BRK: next byte discarded -> IDLE.
//    CLR: NUM_REGS consecutive cycles writing BLANK to addr 0,1,..,NUM_REGS-1;
//      after last write: busy=0, cursor=0, IDLE. scan_valid ignored throughout.
//  - scan_valid with busy=1: byte lost, no state change.
//  - Back-to-back scan_valid on consecutive cycles: each byte processed in order;
//    consecutive writes appear on consecutive cycles.
// TESTING
//  1 Reset, send 1C,32,21 -> writes 0x141@0, 0x142@1, 0x143@2; cursor=3.
//  2 Send 1C, F0,1C -> one write 0x141@0 only; release byte does not write.
//  3 Send E0,75 then E0,F0,75 then 45 -> single write 0x130@0, FSM back in IDLE.
//  4 Send 17 printable bytes -> 16th writes addr 15, 17th writes addr 0;
//    cursor=1 at end.
//  5 Send 1C,32,66 -> BLANK written @1, cursor=1; with cursor=0, 66 ->
//    no wr_en pulse.
//  6 Send 76 then 1C during sweep -> 16 BLANK writes addr 0..15, busy high
//    16 cycles, 1C dropped, cursor=0; pull rst low mid-sweep -> wr_en=0
//    immediately, busy=0.

Source files
------------

// File: rtl/kbd_text_writer_if.sv
// Scan-byte input and text-buffer write port of the keyboard text writer.
interface kbd_text_writer_if #(
  parameter int ADDR_W = 4,
  parameter int SIZE   = 32
);
  logic              scan_valid;
  logic [7:0]        scan_code;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE-1:0]   wr_data;
  logic [ADDR_W-1:0] cursor;
  logic              busy;

  modport master (
    output scan_valid, scan_code,
    input  wr_en, wr_addr, wr_data, cursor, busy
  );

  modport slave (
    input  scan_valid, scan_code,
    output wr_en, wr_addr, wr_data, cursor, busy
  );
endinterface

// File: rtl/kbd_text_writer.sv
// Turns PS/2 set-2 scan bytes into character writes for a small text buffer,
// tracking a cursor and handling release/extended prefixes, backspace, enter, clear.
//
// state     | meaning
// S_IDLE    | waiting for a make code
// S_BRK     | F0 seen, next byte is a release code to drop
// S_EXT     | E0 seen, next byte is an extended key (dropped) or F0
// S_EXT_BRK | E0 F0 seen, next byte is an extended release to drop
// S_CLR     | sweeping BLANK over every cell, input ignored
module kbd_text_writer #(
  parameter int              NUM_REGS = 16,
  parameter int              ADDR_W   = 4,
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] BLANK    = SIZE'(32'h120)
) (
  input logic           clk,
  input logic           rst,
  kbd_text_writer_if.slave kb
);

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_CLR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic       accept;
  logic [8:0] ascii;

  // {mapped, ascii}
  function automatic logic [8:0] map_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return {1'b1, 8'h41}; 8'h32: return {1'b1, 8'h42};
      8'h21: return {1'b1, 8'h43}; 8'h23: return {1'b1, 8'h44};
      8'h24: return {1'b1, 8'h45}; 8'h2B: return {1'b1, 8'h46};
      8'h34: return {1'b1, 8'h47}; 8'h33: return {1'b1, 8'h48};
      8'h43: return {1'b1, 8'h49}; 8'h3B: return {1'b1, 8'h4A};
      8'h42: return {1'b1, 8'h4B}; 8'h4B: return {1'b1, 8'h4C};
      8'h3A: return {1'b1, 8'h4D}; 8'h31: return {1'b1, 8'h4E};
      8'h44: return {1'b1, 8'h4F}; 8'h4D: return {1'b1, 8'h50};
      8'h15: return {1'b1, 8'h51}; 8'h2D: return {1'b1, 8'h52};
      8'h1B: return {1'b1, 8'h53}; 8'h2C: return {1'b1, 8'h54};
      8'h3C: return {1'b1, 8'h55}; 8'h2A: return {1'b1, 8'h56};
      8'h1D: return {1'b1, 8'h57}; 8'h22: return {1'b1, 8'h58};
      8'h35: return {1'b1, 8'h59}; 8'h1A: return {1'b1, 8'h5A};
      8'h45: return {1'b1, 8'h30}; 8'h16: return {1'b1, 8'h31};
      8'h1E: return {1'b1, 8'h32}; 8'h26: return {1'b1, 8'h33};
      8'h25: return {1'b1, 8'h34}; 8'h2E: return {1'b1, 8'h35};
      8'h36: return {1'b1, 8'h36}; 8'h3D: return {1'b1, 8'h37};
      8'h3E: return {1'b1, 8'h38}; 8'h46: return {1'b1, 8'h39};
      8'h29: return {1'b1, 8'h20};
      default: return 9'h000;
    endcase
  endfunction

  assign accept = kb.scan_valid && !busy_q;
  assign ascii  = map_ascii(kb.scan_code);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cursor_d  = cursor_q;
    busy_d    = busy_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (kb.scan_code == 8'hF0) begin
            state_d = S_BRK;
          end else if (kb.scan_code == 8'hE0) begin
            state_d = S_EXT;
          end else if (ascii[8]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q;
            wr_data_d = {{(SIZE-9){1'b0}}, 1'b1, ascii[7:0]};
            cursor_d  = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
          end else if (kb.scan_code == 8'h66) begin
            if (cursor_q != '0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q - 1'b1;
              wr_data_d = BLANK;
              cursor_d  = cursor_q - 1'b1;
            end
          end else if (kb.scan_code == 8'h5A) begin
            cursor_d = '0;
          end else if (kb.scan_code == 8'h76) begin
            // first sweep write issues together with entering the clear
            state_d   = S_CLR;
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = BLANK;
            clr_cnt_d = LAST;
          end
        end
      end
      S_BRK:     if (accept) state_d = S_IDLE;
      S_EXT:     if (accept) state_d = (kb.scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
      S_EXT_BRK: if (accept) state_d = S_IDLE;
      S_CLR: begin
        if (clr_cnt_q == '0) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          cursor_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = BLANK;
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK;
      cursor_q  <= '0;
      busy_q    <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cursor_q  <= cursor_d;
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign kb.wr_en   = wr_en_q;
  assign kb.wr_addr = wr_addr_q;
  assign kb.wr_data = wr_data_q;
  assign kb.cursor  = cursor_q;
  assign kb.busy    = busy_q;

endmodule

// File: tb/tb_kbd_text_writer.sv
// Randomized and directed bench for kbd_text_writer, checked every cycle against
// a behavioural model of the keyboard-to-text rules.
module tb_kbd_text_writer;
  localparam logic [31:0] BLANK = 32'h120;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kbd_text_writer_if #(.ADDR_W(4), .SIZE(32)) kb ();

  kbd_text_writer #(.NUM_REGS(16), .ADDR_W(4), .SIZE(32), .BLANK(BLANK)) dut (
    .clk(clk),
    .rst(rst),
    .kb (kb)
  );

  int tests = 0;
  int fails = 0;

  // behavioural model
  logic [7:0]  ascii_of [bit [7:0]];
  bit   [7:0]  codes [37] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,8'h45,8'h16,8'h1E,8'h26,
                             8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h29};
  string       chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
  string       m_mode;
  int          m_clr [$];
  bit          m_clearing;
  bit          exp_wr_en;
  int          exp_addr;
  logic [31:0] exp_data;
  int          exp_cursor;
  bit          exp_busy;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t log_q [$];
  int  busy_cycles;

  initial begin
    for (int i = 0; i < 37; i++) ascii_of[codes[i]] = chars[i];
  end

  task automatic model_write(input int a, input logic [31:0] d);
    exp_wr_en = 1'b1;
    exp_addr  = a;
    exp_data  = d;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = "idle"; m_clr.delete(); m_clearing = 0;
      exp_wr_en = 0; exp_addr = 0; exp_data = BLANK; exp_cursor = 0; exp_busy = 0;
    end else begin
      exp_wr_en = 0;
      if (m_clearing) begin
        if (m_clr.size() > 0) model_write(m_clr.pop_front(), BLANK);
        else begin m_clearing = 0; exp_busy = 0; exp_cursor = 0; end
      end else if (kb.scan_valid) begin
        logic [7:0] b;
        b = kb.scan_code;
        if (m_mode == "brk" || m_mode == "extbrk") m_mode = "idle";
        else if (m_mode == "ext") m_mode = (b == 8'hF0) ? "extbrk" : "idle";
        else if (b == 8'hF0) m_mode = "brk";
        else if (b == 8'hE0) m_mode = "ext";
        else if (ascii_of.exists(b)) begin
          model_write(exp_cursor, 32'h100 | 32'(ascii_of[b]));
          exp_cursor = (exp_cursor + 1) % 16;
        end else if (b == 8'h66) begin
          if (exp_cursor > 0) begin exp_cursor--; model_write(exp_cursor, BLANK); end
        end else if (b == 8'h5A) exp_cursor = 0;
        else if (b == 8'h76) begin
          for (int i = 0; i < 16; i++) m_clr.push_back(i);
          m_clearing = 1; exp_busy = 1;
          model_write(m_clr.pop_front(), BLANK);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // per-cycle compare and write logging
  always @(negedge clk) begin
    if (rst) begin
      check("wr_en", 32'(kb.wr_en), 32'(exp_wr_en));
      if (exp_wr_en) begin
        check("wr_addr", 32'(kb.wr_addr), 32'(exp_addr));
        check("wr_data", kb.wr_data, exp_data);
      end
      check("cursor", 32'(kb.cursor), 32'(exp_cursor));
      check("busy", 32'(kb.busy), 32'(exp_busy));
      if (kb.wr_en) log_q.push_back('{int'(kb.wr_addr), kb.wr_data});
      if (kb.busy) busy_cycles++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b0;
    log_q.delete(); busy_cycles = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    kb.scan_valid = 1'b1; kb.scan_code = b;
    @(posedge clk); #2;
    kb.scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    kb.scan_valid = 1'b0;
    kb.scan_code  = 8'h00;
    busy_cycles   = 0;
    #12;
    check("rst_wr_en", 32'(kb.wr_en), 0);
    check("rst_wr_addr", 32'(kb.wr_addr), 0);
    check("rst_wr_data", kb.wr_data, 32'h120);
    check("rst_cursor", 32'(kb.cursor), 0);
    check("rst_busy", 32'(kb.busy), 0);
    do_reset();

    // three letters
    send(8'h1C); send(8'h32); send(8'h21); idle(3);
    check("t1_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t1_w0", log_q[0].data, 32'h141); check("t1_a0", log_q[0].addr, 0);
      check("t1_w1", log_q[1].data, 32'h142); check("t1_a1", log_q[1].addr, 1);
      check("t1_w2", log_q[2].data, 32'h143); check("t1_a2", log_q[2].addr, 2);
    end
    check("t1_cursor", 32'(kb.cursor), 3);

    // release suppressed
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C); idle(3);
    check("t2_count", log_q.size(), 1);
    if (log_q.size() == 1) check("t2_w0", log_q[0].data, 32'h141);

    // extended make and release dropped
    do_reset();
    foreach (codes[i]) if (i < 0) send(8'h00);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h45); idle(3);
    check("t3_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t3_w0", log_q[0].data, 32'h130); check("t3_a0", log_q[0].addr, 0);
    end

    // cursor wrap, sent back to back
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < 17; i++) begin
      kb.scan_valid = 1'b1; kb.scan_code = codes[i];
      @(posedge clk); #2;
    end
    kb.scan_valid = 1'b0;
    idle(3);
    check("t4_count", log_q.size(), 17);
    if (log_q.size() == 17) begin
      check("t4_a15", log_q[15].addr, 15);
      check("t4_a16", log_q[16].addr, 0);
    end
    check("t4_cursor", 32'(kb.cursor), 1);

    // backspace
    do_reset();
    send(8'h1C); send(8'h32); send(8'h66); idle(3);
    check("t5_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t5_bs_data", log_q[2].data, 32'h120); check("t5_bs_addr", log_q[2].addr, 1);
    end
    check("t5_cursor", 32'(kb.cursor), 1);
    do_reset();
    send(8'h66); idle(3);
    check("t5_bs0_count", log_q.size(), 0);

    // clear sweep with dropped byte
    do_reset();
    send(8'h76); send(8'h1C); idle(20);
    check("t6_count", log_q.size(), 16);
    for (int i = 0; i < log_q.size() && i < 16; i++) begin
      check("t6_addr", log_q[i].addr, i);
      check("t6_data", log_q[i].data, 32'h120);
    end
    check("t6_busy_cycles", busy_cycles, 16);
    check("t6_cursor", 32'(kb.cursor), 0);
    send(8'h1C); send(8'h76); idle(4);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(kb.wr_en), 0);
    check("t6_rst_busy", 32'(kb.busy), 0);
    check("t6_rst_cursor", 32'(kb.cursor), 0);
    idle(2);
    #1 rst = 1'b1;
    idle(20);

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      @(posedge clk); #2;
      kb.scan_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 99);
      if      (r < 55) kb.scan_code = codes[$urandom_range(0, 36)];
      else if (r < 63) kb.scan_code = 8'hF0;
      else if (r < 68) kb.scan_code = 8'hE0;
      else if (r < 78) kb.scan_code = 8'h66;
      else if (r < 83) kb.scan_code = 8'h5A;
      else if (r < 85) kb.scan_code = 8'h76;
      else if (r < 90) kb.scan_code = (r < 88) ? 8'h12 : 8'h59;
      else             kb.scan_code = 8'($urandom_range(0, 255));
    end
    kb.scan_valid = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
